// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and line/status outputs of the buffered UART transmitter.
// The master drives bytes in; the slave (the transmitter) reports queue state and the line.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   logic [7:0]                  data;
   logic                        valid;
   logic                        ready;
   logic                        tx_data;
   logic                        busy;
   logic [$clog2(FIFO_DEPTH):0] count;

   modport master (
      output data,
      output valid,
      input  ready,
      input  tx_data,
      input  busy,
      input  count
   );

   modport slave (
      input  data,
      input  valid,
      output ready,
      output tx_data,
      output busy,
      output count
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Queued bytes go out back-to-back with a single idle cycle between frames.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
   localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic [7:0]    shift_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic          tx_q;
   logic          push_en;
   logic          pop_en;
   logic          baud_done;

   assign bus.ready   = (count_q != FULL_COUNT);
   assign bus.count   = count_q;
   assign bus.tx_data = tx_q;
   assign bus.busy    = (state_q != IDLE) || (count_q != '0);

   // Fullness is judged before any same-edge pop, so a write to a full FIFO is always refused.
   assign push_en   = bus.valid && bus.ready;
   assign pop_en    = (state_q == IDLE) && (count_q != '0);
   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      count_d = count_q;
      if (push_en && !pop_en) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_en && !push_en) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= bus.data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_en) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   // The line register follows the state one cycle later, keeping the pin purely registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         unique case (state_q)
            START:   tx_q <= 1'b0;
            DATA:    tx_q <= shift_q[0];
            default: tx_q <= 1'b1;
         endcase

         unique case (state_q)
            IDLE: begin
               if (pop_en) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-position reference model, a line decoder,
// directed scenarios with literal expectations, random traffic and a 217-clock loopback.
module tb_uart_tx_fifo;
   localparam int C  = 4;
   localparam int C2 = 217;
   localparam int D  = 8;
   localparam int PERIOD = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.FIFO_DEPTH(D)) u_if ();
   uart_tx_fifo_if #(.FIFO_DEPTH(D)) u_if2 ();

   uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(D)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (u_if2.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus the position inside the frame now on the wire.
   logic [7:0] m_q[$];
   logic [7:0] exp_rx[$];
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   logic [7:0] m_byte   = 8'h00;
   logic       m_tx     = 1'b1;

   function automatic logic frame_bit(input logic [7:0] b, input int pos);
      int idx;
      idx = pos / C;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         exp_rx.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_tx     = 1'b1;
      end else begin
         bit do_pop;
         bit do_push;
         do_pop  = !m_active && (m_q.size() != 0);
         do_push = (u_if.valid === 1'b1) && (m_q.size() < D);
         // The pin shows the frame position one cycle after the FSM reaches it.
         m_tx = m_active ? frame_bit(m_byte, m_pos) : 1'b1;
         if (m_active) begin
            m_pos++;
            if (m_pos == 10 * C) m_active = 1'b0;
         end
         if (do_pop) begin
            m_byte   = m_q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
            exp_rx.push_back(m_byte);
         end
         if (do_push) m_q.push_back(u_if.data);
      end
   end

   always @(negedge clk) begin
      chk("count", u_if.count, m_q.size());
      chk("ready", u_if.ready, m_q.size() != D);
      chk("busy", u_if.busy, m_active || (m_q.size() != 0));
      chk("tx_data", u_if.tx_data, m_tx);
   end

   // Line decoder for the fast instance: samples bit centres from the start edge.
   logic [7:0] got[$];
   longint     start_t[$];
   bit         dec_on  = 1'b0;
   int         dec_cnt = 0;
   logic [7:0] dec_sh  = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         dec_on = 1'b0;
      end else if (!dec_on) begin
         if (u_if.tx_data === 1'b0) begin
            dec_on  = 1'b1;
            dec_cnt = 0;
            start_t.push_back($time);
         end
      end else begin
         dec_cnt++;
         if (dec_cnt >= C + C / 2 && dec_cnt < 9 * C + C / 2 && ((dec_cnt - C / 2) % C) == 0)
            dec_sh[(dec_cnt - C / 2) / C - 1] = u_if.tx_data;
         if (dec_cnt == 9 * C + C / 2) begin
            chk("rx_stop_bit", u_if.tx_data, 1);
            chk("rx_frame_expected", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) chk("rx_byte", dec_sh, exp_rx.pop_front());
            got.push_back(dec_sh);
            dec_on = 1'b0;
         end
      end
   end

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while ((u_if.busy !== 1'b0 || dec_on) && t < budget) begin
         @(posedge clk);
         t++;
      end
      chk("idle_within_budget", t < budget, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic rx_byte(output logic [7:0] b, output bit ok);
      int t;
      t  = 0;
      ok = 1'b0;
      b  = 8'h00;
      while (u_if2.tx_data !== 1'b0 && t < 20 * C2) begin
         @(negedge clk);
         t++;
      end
      if (u_if2.tx_data !== 1'b0) return;
      repeat (C2 / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
         repeat (C2) @(negedge clk);
         b[j] = u_if2.tx_data;
      end
      repeat (C2) @(negedge clk);
      ok = (u_if2.tx_data === 1'b1);
   endtask

   initial begin
      logic [7:0] t2_bytes [3];
      int         t2_cnt   [3];
      logic [7:0] lb_bytes [3];
      int         sent;
      int         cyc;
      logic       r;

      t2_bytes = '{8'hA5, 8'h3C, 8'hFF};
      t2_cnt   = '{1, 1, 2};
      lb_bytes = '{8'h00, 8'h7E, 8'hFF};
      u_if.valid  = 1'b0;
      u_if.data   = 8'h00;
      u_if2.valid = 1'b0;
      u_if2.data  = 8'h00;

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_tx", u_if.tx_data, 1);
      chk("reset_ready", u_if.ready, 1);
      chk("reset_busy", u_if.busy, 0);
      chk("reset_count", u_if.count, 0);

      // Single byte 0x55.
      got.delete();
      u_if.data  = 8'h55;
      u_if.valid = 1'b1;
      @(posedge clk);
      #1 u_if.valid = 1'b0;
      chk("t1_count_after_write", u_if.count, 1);
      @(posedge clk);
      #1 chk("t1_tx_idle_n1", u_if.tx_data, 1);
      @(posedge clk);
      #1 chk("t1_tx_start_n2", u_if.tx_data, 0);
      for (int j = 0; j < 8; j++) begin
         repeat (C) @(posedge clk);
         #1 chk("t1_data_bit", u_if.tx_data, (j % 2 == 0) ? 1 : 0);
      end
      repeat (C) @(posedge clk);
      #1 chk("t1_stop_bit", u_if.tx_data, 1);
      repeat (2) @(posedge clk);
      #1 chk("t1_busy_n40", u_if.busy, 1);
      @(posedge clk);
      #1 chk("t1_busy_n41", u_if.busy, 0);
      wait_idle(200);
      chk("t1_frames", got.size(), 1);
      if (got.size() == 1) chk("t1_byte", got[0], 8'h55);

      // Back-to-back frames.
      got.delete();
      start_t.delete();
      for (int i = 0; i < 3; i++) begin
         u_if.valid = 1'b1;
         u_if.data  = t2_bytes[i];
         @(posedge clk);
         #1 chk("t2_count_step", u_if.count, t2_cnt[i]);
      end
      u_if.valid = 1'b0;
      wait_idle(400);
      chk("t2_frames", got.size(), 3);
      for (int i = 0; i < got.size() && i < 3; i++) chk("t2_byte", got[i], t2_bytes[i]);
      for (int i = 1; i < start_t.size() && i < 3; i++)
         chk("t2_start_spacing", 32'(start_t[i] - start_t[i-1]), (10 * C + 1) * PERIOD);

      // Overfill: 10 writes into a depth-8 FIFO.
      got.delete();
      for (int i = 0; i < 10; i++) begin
         u_if.valid = 1'b1;
         u_if.data  = i[7:0];
         @(posedge clk);
         #1;
         if (i == 7) chk("t3_ready_before_full", u_if.ready, 1);
         if (i == 8) begin
            chk("t3_ready_full", u_if.ready, 0);
            chk("t3_count_full", u_if.count, 8);
         end
      end
      u_if.valid = 1'b0;
      chk("t3_count_after_drop", u_if.count, 8);
      wait_idle(1000);
      chk("t3_frames", got.size(), 9);
      for (int i = 0; i < got.size() && i < 9; i++) chk("t3_byte", got[i], i);

      // Ready-gated stream of 20 bytes, wrapping the pointers.
      got.delete();
      sent = 0;
      cyc  = 0;
      while (sent < 20 && cyc < 3000) begin
         r          = u_if.ready;
         u_if.valid = 1'b1;
         u_if.data  = 8'h40 + sent[7:0];
         @(posedge clk);
         #1;
         cyc++;
         if (r) sent++;
      end
      u_if.valid = 1'b0;
      chk("t4_all_sent", sent, 20);
      wait_idle(2000);
      chk("t4_frames", got.size(), 20);
      for (int i = 0; i < got.size() && i < 20; i++) chk("t4_byte", got[i], 8'h40 + i);

      // Random traffic, ignoring ready so that drops occur.
      for (int k = 0; k < 400; k++) begin
         u_if.valid = ($urandom_range(0, 3) == 0);
         u_if.data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      u_if.valid = 1'b0;
      wait_idle(1000);
      chk("t5_all_decoded", exp_rx.size(), 0);

      // Asynchronous reset during data bit 3 of 0xF0 with two bytes queued.
      got.delete();
      for (int i = 0; i < 3; i++) begin
         u_if.valid = 1'b1;
         u_if.data  = (i == 0) ? 8'hF0 : (i == 1) ? 8'h5A : 8'hC3;
         @(posedge clk);
         #1;
      end
      u_if.valid = 1'b0;
      chk("t6_count_queued", u_if.count, 2);
      repeat (17) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("t6_reset_tx", u_if.tx_data, 1);
      chk("t6_reset_count", u_if.count, 0);
      chk("t6_reset_ready", u_if.ready, 1);
      chk("t6_reset_busy", u_if.busy, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      u_if.valid = 1'b1;
      u_if.data  = 8'h81;
      @(posedge clk);
      #1 u_if.valid = 1'b0;
      wait_idle(200);
      chk("t6_frames", got.size(), 1);
      if (got.size() == 1) chk("t6_byte", got[0], 8'h81);

      // Loopback at 217 clocks per bit.
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               u_if2.valid = 1'b1;
               u_if2.data  = lb_bytes[i];
               @(posedge clk);
               #1;
            end
            u_if2.valid = 1'b0;
         end
         begin
            logic [7:0] rb;
            bit         ok;
            for (int i = 0; i < 3; i++) begin
               rx_byte(rb, ok);
               chk("t7_frame_ok", ok, 1);
               chk("t7_byte", rb, lb_bytes[i]);
            end
         end
      join
      repeat (C2) @(posedge clk);
      #1;
      chk("t7_busy_done", u_if2.busy, 0);
      chk("t7_line_idle", u_if2.tx_data, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
